// File: rtl/wb_arbiter2.sv
// Two-master to one-slave pipelined Wishbone arbiter.
// Master 0 is instruction fetch and master 1 is the data bus.
// A grant is held until every accepted request has been acknowledged.
// A watchdog turns a silent slave into a bus error on the owning master.
module wb_arbiter2 #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_PENDING = 8,
    parameter int TIMEOUT     = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    // master 0 (instruction)
    input  logic            m0_cyc,
    input  logic            m0_stb,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_adr,
    input  logic [DW/8-1:0] m0_sel,
    input  logic [DW-1:0]   m0_dat_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack,
    output logic            m0_err,
    output logic            m0_stall,
    // master 1 (data)
    input  logic            m1_cyc,
    input  logic            m1_stb,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_adr,
    input  logic [DW/8-1:0] m1_sel,
    input  logic [DW-1:0]   m1_dat_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack,
    output logic            m1_err,
    output logic            m1_stall,
    // slave
    output logic            s_cyc,
    output logic            s_stb,
    output logic            s_we,
    output logic [AW-1:0]   s_adr,
    output logic [DW/8-1:0] s_sel,
    output logic [DW-1:0]   s_dat_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack,
    input  logic            s_err,
    input  logic            s_stall,
    // debug
    output logic [1:0]      grant
);

    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [PW-1:0] P_MAX  = PW'(MAX_PENDING);
    localparam logic [PW-1:0] P_ONE  = PW'(1);
    localparam logic [WW-1:0] W_MAX  = (TIMEOUT > 0) ? WW'(TIMEOUT) : '0;
    localparam logic [WW-1:0] W_LAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;
    localparam logic [WW-1:0] W_ONE  = WW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t        r_state;
    logic          r_last_grant;   // 1: master 1 was granted most recently
    logic [PW-1:0] r_pending;
    logic [WW-1:0] r_wdog;

    state_t        w_state_nxt;
    state_t        w_arb;
    logic          w_last_nxt;
    logic [PW-1:0] w_pending_nxt;
    logic [WW-1:0] w_wdog_nxt;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_granted;
    logic          w_mcyc;
    logic          w_mstb;
    logic          w_pend_nz;
    logic          w_pend_full;
    logic          w_timeout;
    logic          w_release;
    logic          w_accept;
    logic          w_retire;
    logic          w_stall_g;

    assign w_gnt0      = (r_state == GNT0);
    assign w_gnt1      = (r_state == GNT1);
    assign w_granted   = w_gnt0 | w_gnt1;
    assign w_mcyc      = w_gnt1 ? m1_cyc : (w_gnt0 & m0_cyc);
    assign w_mstb      = w_gnt1 ? m1_stb : (w_gnt0 & m0_stb);
    assign w_pend_nz   = (r_pending != '0);
    assign w_pend_full = (r_pending == P_MAX);
    // The timeout fires on the TIMEOUT-th cycle with work outstanding and
    // no response; a response arriving in that same cycle loses to the error.
    assign w_timeout   = (TIMEOUT > 0) && w_granted && w_pend_nz && (r_wdog == W_LAST);
    assign w_release   = ~w_mcyc & ~w_pend_nz;

    // Slave side: forwarded from the owner, silenced while idle or timing out
    assign s_cyc     = w_granted & (w_mcyc | w_pend_nz) & ~w_timeout;
    assign s_stb     = w_granted & w_mcyc & w_mstb & (r_pending < P_MAX) & ~w_timeout;
    assign s_we      = w_gnt1 ? m1_we    : m0_we;
    assign s_adr     = w_gnt1 ? m1_adr   : m0_adr;
    assign s_sel     = w_gnt1 ? m1_sel   : m0_sel;
    assign s_dat_o   = w_gnt1 ? m1_dat_i : m0_dat_i;

    // Master side: only the owner sees responses and may be unstalled
    assign w_stall_g = s_stall | w_pend_full;
    assign m0_stall  = w_gnt0 ? w_stall_g : 1'b1;
    assign m1_stall  = w_gnt1 ? w_stall_g : 1'b1;
    assign m0_ack    = w_gnt0 & s_ack & ~w_timeout;
    assign m1_ack    = w_gnt1 & s_ack & ~w_timeout;
    assign m0_err    = w_gnt0 & (s_err | w_timeout);
    assign m1_err    = w_gnt1 & (s_err | w_timeout);
    assign m0_dat_o  = s_dat_i;
    assign m1_dat_o  = s_dat_i;
    assign grant     = r_state;

    assign w_accept  = s_stb & ~s_stall;
    assign w_retire  = w_granted & (s_ack | s_err) & w_pend_nz;

    // Round-robin choice between requesting masters, tie goes opposite last owner
    always_comb begin
        w_arb = IDLE;
        if (m0_cyc && m1_cyc)
            w_arb = r_last_grant ? GNT0 : GNT1;
        else if (m0_cyc)
            w_arb = GNT0;
        else if (m1_cyc)
            w_arb = GNT1;
    end

    // Next-state: arbitrate from IDLE or in the release cycle of a grant
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last_grant;
        case (r_state)
            IDLE: begin
                w_state_nxt = w_arb;
                if (w_arb != IDLE)
                    w_last_nxt = (w_arb == GNT1);
            end
            GNT0, GNT1: begin
                if (w_release) begin
                    w_state_nxt = w_arb;
                    if (w_arb != IDLE)
                        w_last_nxt = (w_arb == GNT1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outstanding-request count and watchdog for the current grant
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_timeout)
            w_pending_nxt = '0;
        else if (w_accept && !w_retire)
            w_pending_nxt = r_pending + P_ONE;
        else if (w_retire && !w_accept)
            w_pending_nxt = r_pending - P_ONE;

        w_wdog_nxt = r_wdog;
        if (!w_granted || !w_pend_nz || s_ack || s_err || w_timeout)
            w_wdog_nxt = '0;
        else if (r_wdog != W_MAX)
            w_wdog_nxt = r_wdog + W_ONE;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b0;
            r_pending    <= '0;
            r_wdog       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_nxt;
            r_pending    <= w_pending_nxt;
            r_wdog       <= w_wdog_nxt;
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed self-checking bench for wb_arbiter2.
// A second instance with a short timeout covers the watchdog path.
module tb_wb_arbiter2;

    localparam logic [31:0] A0 = 32'h1000_0040;
    localparam logic [31:0] A1 = 32'h2000_0080;
    localparam logic [31:0] D0 = 32'hAAAA_0000;
    localparam logic [31:0] D1 = 32'h5555_1111;
    localparam logic [31:0] DI = 32'hCAFE_F00D;
    localparam logic [3:0]  S0 = 4'hF;
    localparam logic [3:0]  S1 = 4'h3;

    logic clk = 1'b0;
    logic rst;
    logic m0_cyc, m0_stb, m1_cyc, m1_stb;
    logic s_ack, s_err, s_stall;

    logic [31:0] m0_dat_o, m1_dat_o, s_adr, s_dat_o;
    logic [3:0]  s_sel;
    logic        m0_ack, m0_err, m0_stall, m1_ack, m1_err, m1_stall;
    logic        s_cyc, s_stb, s_we;
    logic [1:0]  grant;

    logic [31:0] t_m0_dat_o, t_m1_dat_o, t_s_adr, t_s_dat_o;
    logic [3:0]  t_s_sel;
    logic        t_m0_ack, t_m0_err, t_m0_stall, t_m1_ack, t_m1_err, t_m1_stall;
    logic        t_s_cyc, t_s_stb, t_s_we;
    logic [1:0]  t_grant;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_arbiter2 #(.AW(32), .DW(32), .MAX_PENDING(8), .TIMEOUT(255)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(1'b0), .m0_adr(A0), .m0_sel(S0),
        .m0_dat_i(D0), .m0_dat_o(m0_dat_o), .m0_ack(m0_ack), .m0_err(m0_err), .m0_stall(m0_stall),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(1'b1), .m1_adr(A1), .m1_sel(S1),
        .m1_dat_i(D1), .m1_dat_o(m1_dat_o), .m1_ack(m1_ack), .m1_err(m1_err), .m1_stall(m1_stall),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
        .s_dat_o(s_dat_o), .s_dat_i(DI), .s_ack(s_ack), .s_err(s_err), .s_stall(s_stall),
        .grant(grant)
    );

    wb_arbiter2 #(.AW(32), .DW(32), .MAX_PENDING(8), .TIMEOUT(4)) dut_to (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(1'b0), .m0_adr(A0), .m0_sel(S0),
        .m0_dat_i(D0), .m0_dat_o(t_m0_dat_o), .m0_ack(t_m0_ack), .m0_err(t_m0_err), .m0_stall(t_m0_stall),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(1'b1), .m1_adr(A1), .m1_sel(S1),
        .m1_dat_i(D1), .m1_dat_o(t_m1_dat_o), .m1_ack(t_m1_ack), .m1_err(t_m1_err), .m1_stall(t_m1_stall),
        .s_cyc(t_s_cyc), .s_stb(t_s_stb), .s_we(t_s_we), .s_adr(t_s_adr), .s_sel(t_s_sel),
        .s_dat_o(t_s_dat_o), .s_dat_i(DI), .s_ack(s_ack), .s_err(s_err), .s_stall(s_stall),
        .grant(t_grant)
    );

    // inputs: rst c0 b0 c1 b1 ack stall ; expected: grant cyc stb st0 st1 ack0 ack1
    typedef struct packed {
        logic       rst, c0, b0, c1, b1, ack, stl;
        logic [1:0] g;
        logic       cyc, stb, st0, st1, ak0, ak1;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int acc;

        // single master m1: three pipelined reads, 0-wait slave
        tbl.push_back({7'b0_00_00_0_0, 8'b00_0_0_1_1_0_0});
        tbl.push_back({7'b0_00_11_0_0, 8'b00_0_0_1_1_0_0});
        tbl.push_back({7'b0_00_11_0_0, 8'b10_1_1_1_0_0_0});
        tbl.push_back({7'b0_00_11_1_0, 8'b10_1_1_1_0_0_1});
        tbl.push_back({7'b0_00_11_1_0, 8'b10_1_1_1_0_0_1});
        tbl.push_back({7'b0_00_10_1_0, 8'b10_1_0_1_0_0_1});
        tbl.push_back({7'b0_00_00_0_0, 8'b10_0_0_1_0_0_0});
        tbl.push_back({7'b0_00_00_0_0, 8'b00_0_0_1_1_0_0});
        // reset, tie -> m1, release, tie -> m0, handoff to m1 with one s_cyc gap
        tbl.push_back({7'b1_00_00_0_0, 8'b00_0_0_1_1_0_0});
        tbl.push_back({7'b0_10_10_0_0, 8'b00_0_0_1_1_0_0});
        tbl.push_back({7'b0_10_11_0_0, 8'b10_1_1_1_0_0_0});
        tbl.push_back({7'b0_10_10_1_0, 8'b10_1_0_1_0_0_1});
        tbl.push_back({7'b0_00_00_0_0, 8'b10_0_0_1_0_0_0});
        tbl.push_back({7'b0_10_10_0_0, 8'b00_0_0_1_1_0_0});
        tbl.push_back({7'b0_11_11_0_0, 8'b01_1_1_0_1_0_0});
        tbl.push_back({7'b0_10_11_1_0, 8'b01_1_0_0_1_1_0});
        tbl.push_back({7'b0_00_11_0_0, 8'b01_0_0_0_1_0_0});
        tbl.push_back({7'b0_00_11_0_1, 8'b10_1_1_1_1_0_0});
        tbl.push_back({7'b0_00_11_0_0, 8'b10_1_1_1_0_0_0});
        tbl.push_back({7'b0_00_10_1_0, 8'b10_1_0_1_0_0_1});
        tbl.push_back({7'b0_00_00_0_0, 8'b10_0_0_1_0_0_0});
        tbl.push_back({7'b0_00_00_0_0, 8'b00_0_0_1_1_0_0});

        rst = 1'b1; m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            rst = tbl[i].rst; m0_cyc = tbl[i].c0; m0_stb = tbl[i].b0;
            m1_cyc = tbl[i].c1; m1_stb = tbl[i].b1; s_ack = tbl[i].ack; s_stall = tbl[i].stl;
            @(negedge clk);
            chk($sformatf("vec%0d_outputs", i),
                {22'd0, grant, s_cyc, s_stb, m0_stall, m1_stall, m0_ack, m1_ack, m0_err, m1_err},
                {22'd0, tbl[i].g, tbl[i].cyc, tbl[i].stb, tbl[i].st0, tbl[i].st1,
                 tbl[i].ak0, tbl[i].ak1, 2'b00});
            if (tbl[i].g == 2'b01) begin
                chk($sformatf("vec%0d_m0_path", i), {s_adr ^ s_dat_o, 27'd0, s_we, s_sel},
                    {A0 ^ D0, 27'd0, 1'b0, S0});
            end else if (tbl[i].g == 2'b10) begin
                chk($sformatf("vec%0d_m1_path", i), {s_adr ^ s_dat_o, 27'd0, s_we, s_sel},
                    {A1 ^ D1, 27'd0, 1'b1, S1});
            end
            tick();
        end
        chk("read_data_m0", m0_dat_o, DI);
        chk("read_data_m1", m1_dat_o, DI);

        // pending limit: m0 streams, slave never acks
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1;
        tick();
        acc = 0;
        repeat (12) begin
            @(negedge clk);
            if (s_stb && !s_stall) acc++;
            tick();
        end
        chk("plim_accepts", acc, 8);
        @(negedge clk);
        chk("plim_stall_full", {m0_stall, s_stb}, 2'b10);
        tick();
        s_ack = 1'b1;
        @(negedge clk);
        chk("plim_ack_route", {m0_ack, s_stb}, 2'b10);
        tick();
        s_ack = 1'b0;
        acc = 0;
        repeat (4) begin
            @(negedge clk);
            if (s_stb && !s_stall) acc++;
            tick();
        end
        chk("plim_one_more", acc, 1);

        // early cyc drop by m1 with two requests outstanding
        do_reset();
        m1_cyc = 1'b1; m1_stb = 1'b1;
        tick();
        tick();
        tick();
        m1_cyc = 1'b0; m1_stb = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
        s_ack = 1'b1;
        @(negedge clk);
        chk("drop_hold1", {grant, s_cyc, s_stb}, 4'b10_1_0);
        tick();
        s_ack = 1'b0;
        @(negedge clk);
        chk("drop_hold2", {grant, s_cyc}, 3'b10_1);
        tick();
        s_ack = 1'b1;
        @(negedge clk);
        chk("drop_last_ack", {grant, s_cyc, m1_ack, m0_stall}, 5'b10_1_1_1);
        tick();
        s_ack = 1'b0;
        @(negedge clk);
        chk("drop_release", {grant, s_cyc, m0_stall}, 4'b10_0_1);
        tick();
        @(negedge clk);
        chk("drop_m0_granted", {grant, s_cyc, m0_stall}, 4'b01_1_0);
        tick();

        // watchdog with TIMEOUT=4: one request, slave silent
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1;
        tick();
        @(negedge clk);
        chk("to_accept", {t_grant, t_s_stb}, 3'b01_1);
        tick();
        m0_stb = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("to_wait%0d", k), {t_m0_err, t_s_cyc}, 2'b01);
            tick();
        end
        s_ack = 1'b1;
        @(negedge clk);
        chk("to_fire", {t_m0_err, t_m0_ack, t_s_cyc, t_s_stb}, 4'b1_0_0_0);
        chk("to_other_master", {t_m1_stall, t_m1_ack, t_m1_err}, 3'b1_0_0);
        chk("to_paths", {t_s_adr ^ t_s_dat_o, 27'd0, t_s_we, t_s_sel}, {A0 ^ D0, 27'd0, 1'b0, S0});
        chk("to_rdata", t_m0_dat_o ^ t_m1_dat_o ^ t_m0_stall, 32'h0);
        tick();
        s_ack = 1'b0;
        @(negedge clk);
        chk("to_after", {t_m0_err, t_grant, t_s_cyc}, 4'b0_01_1);
        tick();
        m0_cyc = 1'b0;
        @(negedge clk);
        chk("to_release_pending0", {t_grant, t_s_cyc}, 3'b01_0);
        tick();
        @(negedge clk);
        chk("to_idle", t_grant, 2'b00);
        tick();

        // reset in the middle of a burst with three pending
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1;
        tick();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b1; m1_stb = 1'b1;
        @(negedge clk);
        chk("rst_mid_idle", {grant, s_cyc, m0_stall, m1_stall}, 5'b00_0_1_1);
        tick();
        @(negedge clk);
        chk("rst_mid_regrant", {grant, s_cyc, s_stb, m1_stall}, 5'b10_1_1_0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
